// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, funct3 size codes
// and the store lane helpers used when an access is latched.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Anything that is neither byte nor half (010, 011, 110, 111) is a word.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        if (is_byte(f3)) return 4'b0001 << lo;
        if (is_half(f3)) return 4'b0011 << lo;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (is_byte(f3)) return {4{d[7:0]}};
        if (is_half(f3)) return {2{d[15:0]}};
        return d;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load alignment: picks the byte/half addressed by addr_lo out of
// the read word and sign- or zero-extends it according to funct3.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [15:0] shifted;

    always_comb begin
        shifted = 16'(rdata >> {addr_lo, 3'b000});
        if (is_byte(funct3)) begin
            load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        end else if (is_half(funct3)) begin
            load_data = funct3[2] ? {16'b0, shifted} : {{16{shifted[15]}}, shifted};
        end else begin
            load_data = rdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging the core's MemRead/MemWrite to a req/gnt/rvalid data bus.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output state_e      fsm_state
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_e        state;
    logic          op_write;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   fmt_data;
    logic          access;
    logic          trap;

    assign access    = mem_read | mem_write;
    assign fsm_state = state;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = access && ((is_half(funct3) && addr[0]) ||
                             (!is_byte(funct3) && !is_half(funct3) && (addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // Stall rises combinationally on the request cycle so the core holds the instruction.
    assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && access && !trap);

    load_formatter u_fmt (
        .rdata     (dmem_rdata),
        .addr_lo   (lo_q),
        .funct3    (f3_q),
        .load_data (fmt_data)
    );

    // Bus handshake: dmem_req holds with stable addr/be/we/wdata until the cycle
    // dmem_gnt is seen high; a read then waits for a single-cycle dmem_rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            f3_q       <= F3_W;
            lo_q       <= 2'b00;
            wait_cnt   <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (trap) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        misaligned <= 1'b1;
`endif
                    end else if (access) begin
                        op_write   <= mem_write;
                        f3_q       <= funct3;
                        lo_q       <= addr[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= lane_be(funct3, addr[1:0]);
                        dmem_wdata <= lane_wdata(funct3, store_data);
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= '0;
                        wait_cnt <= '0;
                        state    <= op_write ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        load_data  <= fmt_data;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        load_data  <= '0;
                        load_valid <= 1'b1;
                        bus_error  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed store lanes, load formatting,
// stall latency, bus-error timeout and reset abort.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned;
`endif
    state_e      fsm_state;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned  (misaligned),
`endif
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          stall_cnt, req_cnt, lv_cnt, err_cnt;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    logic        obs_we;
    bit          finished;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one access and plays the bus side; gnt after gnt_dly REQ cycles,
    // rvalid rv_dly cycles after the gnt cycle (-1: never).
    task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input int gnt_dly, input int rv_dly,
                              input logic [31:0] rdata);
        int gnt_left;
        int rv_cnt;
        bit armed;
        @(negedge clk);
        mem_write  = wr;
        mem_read   = !wr;
        funct3     = f3;
        addr       = a;
        store_data = d;
        dmem_rdata = rdata;
        stall_cnt = 0; req_cnt = 0; lv_cnt = 0; err_cnt = 0;
        obs_addr = 'x; obs_wdata = 'x; obs_ld = 'x; obs_be = 'x; obs_we = 1'bx;
        finished = 1'b0;
        gnt_left = gnt_dly;
        rv_cnt = 0;
        armed = 1'b0;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (dmem_req) begin
                if (gnt_left == 0) begin
                    dmem_gnt = 1'b1;
                    armed = 1'b1;
                    rv_cnt = 0;
                end else begin
                    gnt_left--;
                end
            end else if (armed) begin
                if (rv_dly >= 0 && rv_cnt == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    armed = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end
            #1;
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                obs_addr = dmem_addr; obs_be = dmem_be; obs_we = dmem_we; obs_wdata = dmem_wdata;
            end
            if (load_valid) begin
                lv_cnt++;
                obs_ld = load_data;
            end
            if (bus_error) err_cnt++;
            if (!stall) finished = 1'b1;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        check_eq("access_completes", 32'(finished), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_be", 32'(dmem_be), 32'd0);
        check_eq("rst_lv", 32'(load_valid), 32'd0);
        check_eq("rst_ld", load_data, 32'd0);
        check_eq("rst_berr", 32'(bus_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SW 0x104, immediate gnt
        run_access(1'b1, F3_W, 32'h104, 32'hDEAD_BEEF, 0, 0, 32'h0);
        check_eq("sw_stall", 32'(stall_cnt), 32'd2);
        check_eq("sw_be", 32'(obs_be), 32'hF);
        check_eq("sw_addr", obs_addr, 32'h104);
        check_eq("sw_we", 32'(obs_we), 32'd1);
        check_eq("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        check_eq("sw_lv", 32'(lv_cnt), 32'd0);

        // LB 0x103, minimum latency
        run_access(1'b0, F3_B, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
        check_eq("lb_stall", 32'(stall_cnt), 32'd3);
        check_eq("lb_ld", obs_ld, 32'hFFFF_FF80);
        check_eq("lb_lv", 32'(lv_cnt), 32'd1);
        check_eq("lb_be", 32'(obs_be), 32'h8);
        check_eq("lb_addr", obs_addr, 32'h100);
        check_eq("lb_we", 32'(obs_we), 32'd0);

        // LHU 0x102
        run_access(1'b0, F3_HU, 32'h102, 32'h0, 0, 0, 32'hABCD_1234);
        check_eq("lhu_ld", obs_ld, 32'h0000_ABCD);
        check_eq("lhu_be", 32'(obs_be), 32'hC);

        // SH 0x102
        run_access(1'b1, F3_H, 32'h102, 32'h0000_5678, 0, 0, 32'h0);
        check_eq("sh_be", 32'(obs_be), 32'hC);
        check_eq("sh_wdata", obs_wdata, 32'h5678_5678);

        // LH 0x100 with gnt held off two cycles, negative half
        run_access(1'b0, F3_H, 32'h100, 32'h0, 2, 0, 32'h1234_8001);
        check_eq("lh_stall", 32'(stall_cnt), 32'd5);
        check_eq("lh_req_cycles", 32'(req_cnt), 32'd3);
        check_eq("lh_ld", obs_ld, 32'hFFFF_8001);
        check_eq("lh_be", 32'(obs_be), 32'h3);

        // LBU 0x101
        run_access(1'b0, F3_BU, 32'h101, 32'h0, 0, 1, 32'h0000_9A00);
        check_eq("lbu_ld", obs_ld, 32'h0000_009A);
        check_eq("lbu_stall", 32'(stall_cnt), 32'd4);

        // SB 0x003
        run_access(1'b1, F3_B, 32'h003, 32'h1234_5678, 0, 0, 32'h0);
        check_eq("sb_be", 32'(obs_be), 32'h8);
        check_eq("sb_wdata", obs_wdata, 32'h7878_7878);
        check_eq("sb_addr", obs_addr, 32'h0);

        // LW timeout: rvalid never arrives
        run_access(1'b0, F3_W, 32'h200, 32'h0, 0, -1, 32'h0);
        check_eq("to_stall", 32'(stall_cnt), 32'd6);
        check_eq("to_berr", 32'(err_cnt), 32'd1);
        check_eq("to_ld", load_data, 32'd0);

        // rvalid on the last WAIT cycle beats the timeout
        run_access(1'b0, F3_W, 32'h200, 32'h0, 0, MAX_WAIT - 1, 32'hCAFE_F00D);
        check_eq("late_ld", obs_ld, 32'hCAFE_F00D);
        check_eq("late_berr", 32'(err_cnt), 32'd0);
        check_eq("late_stall", 32'(stall_cnt), 32'd6);

        // LW 0x101: trap with the macro, word-aligned access without it
`ifdef LSU_MISALIGN_TRAP_EN
        run_access(1'b0, F3_W, 32'h101, 32'h0, 0, 0, 32'h55AA_33CC);
        check_eq("mis_stall", 32'(stall_cnt), 32'd0);
        check_eq("mis_req", 32'(req_cnt), 32'd0);
        @(negedge clk);
        #1;
        check_eq("mis_pulse", 32'(misaligned), 32'd1);
        check_eq("mis_state", 32'(fsm_state), 32'(IDLE));
`else
        run_access(1'b0, F3_W, 32'h101, 32'h0, 0, 0, 32'h55AA_33CC);
        check_eq("mis_addr", obs_addr, 32'h100);
        check_eq("mis_be", 32'(obs_be), 32'hF);
        check_eq("mis_ld", obs_ld, 32'h55AA_33CC);
`endif

        // reset during WAIT
        @(negedge clk);
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h300; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check_eq("abort_in_wait", 32'(fsm_state), 32'(WAIT));
        @(negedge clk);
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        check_eq("abort_state", 32'(fsm_state), 32'(IDLE));
        check_eq("abort_stall", 32'(stall), 32'd0);
        check_eq("abort_ld", load_data, 32'd0);
        check_eq("abort_lv", 32'(load_valid), 32'd0);
        check_eq("abort_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check_eq("late_rvalid_lv", 32'(load_valid), 32'd0);
        check_eq("late_rvalid_ld", load_data, 32'd0);
        req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (dmem_req) req_cnt++;
        end
        check_eq("no_reissue", 32'(req_cnt), 32'd0);
        check_eq("idle_after_abort", 32'(fsm_state), 32'(IDLE));

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255: number of WAIT cycles without dmem_rvalid before the access ends as a bus error.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mem_read  in  1  load requested by the current instruction (decoder MemRead).
REQ-005 mem_write  in  1  store requested by the current instruction (decoder MemWrite).
REQ-006 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  byte address from the ALU.
REQ-008 store_data  in  32  rs2 value for stores.
REQ-009 stall  out  1  core SHALL hold the current instruction while high.
REQ-010 load_data  out  32  formatted load result, valid while load_valid=1.
REQ-011 load_valid  out  1  one-cycle pulse: load_data valid.
REQ-012 bus_error  out  1  one-cycle pulse: load timed out.
REQ-013 dmem_req / dmem_we  out  1 / 1  bus request; write when dmem_we=1.
REQ-014 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 dmem_be / dmem_wdata  out  4 / 32  byte enables and lane-positioned write data.
REQ-016 dmem_gnt / dmem_rvalid / dmem_rdata  in  1 / 1 / 32  grant, read-data valid, read data.
REQ-017 misaligned  out  1  one-cycle pulse, present only with LSU_MISALIGN_TRAP_EN.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-019 IDLE: mem_read|mem_write latches addr, funct3, store_data, op -> REQ; stall=1 combinationally in that cycle; mem_write takes priority if both are high.
REQ-020 REQ: dmem_req=1 with latched fields stable until dmem_gnt; gnt on a write -> DONE, on a read -> WAIT.
REQ-021 WAIT: dmem_rvalid captures formatted dmem_rdata -> DONE; an rvalid in the same cycle as the timeout wins.
REQ-022 WAIT counter clears on entry; reaching MAX_WAIT -> DONE with load_data=0 and bus_error=1 in DONE.
REQ-023 DONE: stall=0, load_valid=1 for reads only, -> IDLE; minimum load latency is gnt in REQ plus rvalid in the following cycle, i.e. 3 stall cycles.
REQ-024 Store lanes: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<addr[1:0] truncated to 4 bits, wdata=half replicated x2; SW be=1111.
REQ-025 Load format: the byte or half is selected by addr[1:0]; B/H sign-extend; BU/HU zero-extend; funct3 011/110/111 are treated as W.
REQ-026 dmem_req, dmem_we, dmem_be SHALL be 0 outside REQ.

Reset
REQ-027 rst_n low at any time, including mid-access, forces IDLE; the counter, stall, load_valid, bus_error, misaligned, dmem_req, dmem_we, and dmem_be go to 0, and load_data goes to 0.
REQ-028 An access aborted by reset SHALL NOT be reissued.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 in IDLE -> misaligned=1 for one cycle, no bus access, stall=0, FSM stays IDLE.
REQ-030 Macro undefined: the misaligned port is absent; the access proceeds at the word-aligned address with be truncated per REQ-024.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum and the funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-032 Sub-module load_formatter (combinational: rdata, addr[1:0], funct3 -> load_data) SHALL be instantiated once.

Verification
REQ-033 SW addr=0x104, data=0xDEADBEEF, gnt immediate -> dmem_be=1111, dmem_addr=0x104, stall high 2 cycles, no load_valid.
REQ-034 LB addr=0x103, rdata=0x80FF_FFFF, rvalid one cycle after gnt -> load_data=0xFFFF_FF80, load_valid pulse in DONE.
REQ-035 LHU addr=0x102, rdata=0xABCD_1234 -> load_data=0x0000_ABCD; SH addr=0x102, data=0x5678 -> be=1100, wdata=0x5678_5678.
REQ-036 LW with rvalid never asserted, MAX_WAIT=4 -> bus_error pulse after 4 WAIT cycles, load_data=0, stall released.
REQ-037 rst_n low during WAIT -> immediate IDLE with all outputs 0; a later rvalid is ignored.
REQ-038 LW addr=0x101 with LSU_MISALIGN_TRAP_EN -> misaligned pulse, dmem_req stays 0; without the macro -> access at 0x100 with be=1111.
